// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic unit (multiplier and divider).
package arith_pkg;

    // Operand width used when an instance does not override it.
    localparam int unsigned DefWidth = 4;

    // Control FSM shared by the sequential arithmetic blocks.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StFim  = 2'd2
    } arith_state_e;

    // Step-counter width for a given operand width (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    localparam int unsigned DefCntWidth = cnt_width(DefWidth);

endpackage

// File: rtl/subtrator_restauracao.sv
// One restoring-division step: trial subtraction of the divisor from the shifted
// partial remainder, keeping the difference only when it does not go negative.
module subtrator_restauracao
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic [WIDTH:0]   r_shift,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_next,
    output logic             q_bit
);

    logic [WIDTH:0] trial;

    // The extra bit of R makes the trial MSB a clean borrow flag.
    always_comb begin
        trial  = r_shift - {1'b0, d};
        q_bit  = ~trial[WIDTH];
        r_next = q_bit ? trial : r_shift;
    end

endmodule

// File: rtl/divisor_sequencial.sv
// Sequential restoring divider: one quotient bit per clock, start/done handshake
// shared with the shift-and-add multiplier.
module divisor_sequencial
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    arith_state_e state_q, state_d;

    logic [CntW-1:0]  cnt_q;
    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             div_zero_q;

    // Control strobes decoded from the FSM.
    logic load_op;
    logic load_zero;
    logic step;
    logic finish;

    // Shifted {R,Q} pair and the step result.
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   r_next;
    logic             q_bit;
    logic [WIDTH-1:0] q_next;

    // {R,Q} <<= 1; R never exceeds WIDTH significant bits between steps.
    always_comb begin
        r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        q_next  = {q_q[WIDTH-2:0], q_bit};
    end

    subtrator_restauracao #(
        .WIDTH (WIDTH)
    ) u_subtrator (
        .r_shift (r_shift),
        .d       (d_q),
        .r_next  (r_next),
        .q_bit   (q_bit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        load_op   = 1'b0;
        load_zero = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (divisor != '0) begin
                        load_op = 1'b1;
                        state_d = StCalc;
                    end else begin
                        // Divide by zero skips the iteration entirely.
                        load_zero = 1'b1;
                        state_d   = StFim;
                    end
                end
            end
            StCalc: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt_q == LastCnt) begin
                    finish  = 1'b1;
                    state_d = StFim;
                end
            end
            StFim: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Working registers (R, Q, D, step counter) and the held results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            if (load_op) begin
                cnt_q      <= '0;
                r_q        <= '0;
                q_q        <= dividend;
                d_q        <= divisor;
                div_zero_q <= 1'b0;
            end
            if (load_zero) begin
                quotient_q  <= '1;
                remainder_q <= dividend;
                div_zero_q  <= 1'b1;
            end
            if (step) begin
                r_q   <= r_next;
                q_q   <= q_next;
                cnt_q <= cnt_q + CntOne;
            end
            // Final step result goes straight to the outputs.
            if (finish) begin
                quotient_q  <= q_next;
                remainder_q <= r_next[WIDTH-1:0];
            end
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_divisor_sequencial.sv
// Directed self-checking bench for divisor_sequencial (WIDTH=4).
module tb_divisor_sequencial;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;

    int checks = 0;
    int errors = 0;

    divisor_sequencial #(
        .WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One division from IDLE; inputs driven and outputs sampled on falling edges.
    // Cycle k counts falling edges after the accepting rising edge.
    task automatic run_div(input string tag, input logic [3:0] dvd, input logic [3:0] dvs,
                           input logic noise, input logic [3:0] exp_q, input logic [3:0] exp_r,
                           input logic exp_dz, input int exp_lat);
        int   lat;
        int   n_done;
        logic busy_ok;
        logic [3:0] got_q;
        logic [3:0] got_r;
        logic got_dz;
        lat     = 0;
        n_done  = 0;
        busy_ok = 1'b1;
        got_q   = 'x;
        got_r   = 'x;
        got_dz  = 1'bx;
        @(negedge clk);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                if (lat == 0) begin
                    lat    = k;
                    got_q  = quotient;
                    got_r  = remainder;
                    got_dz = div_zero;
                end
            end
            if (busy !== (k < exp_lat)) busy_ok = 1'b0;
            start = 1'b0;
            // Start with junk operands while the divider is busy must be ignored.
            if (noise && (k == 2 || k == 3)) begin
                start    = 1'b1;
                dividend = 4'd1;
                divisor  = 4'd1;
            end
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " done_count"}, n_done, 1);
        check({tag, " busy_window"}, busy_ok, 1);
        check({tag, " quotient"}, got_q, exp_q);
        check({tag, " remainder"}, got_r, exp_r);
        check({tag, " div_zero"}, got_dz, exp_dz);
    endtask

    initial begin
        int   seen_done;
        int   k;
        int   exp_k;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] eq;
        logic [3:0] er;
        logic edz;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset div_zero", div_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_div("13/4", 4'd13, 4'd4, 1'b0, 4'd3, 4'd1, 1'b0, 5);
        run_div("15/1", 4'd15, 4'd1, 1'b0, 4'd15, 4'd0, 1'b0, 5);
        run_div("3/7", 4'd3, 4'd7, 1'b0, 4'd0, 4'd3, 1'b0, 5);
        run_div("0/5", 4'd0, 4'd5, 1'b0, 4'd0, 4'd0, 1'b0, 5);
        run_div("9/0", 4'd9, 4'd0, 1'b0, 4'd15, 4'd9, 1'b1, 1);
        run_div("14/3 ignored start", 4'd14, 4'd3, 1'b1, 4'd4, 4'd2, 1'b0, 5);

        // Reset in cycle 2 of 12/5: outputs clear at once, no done pulse.
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd12;
        divisor  = 4'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort quotient", quotient, 0);
        check("abort remainder", remainder, 0);
        check("abort div_zero", div_zero, 0);
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
            if (i == 2) rst_n = 1'b1;
        end
        check("abort no_done", seen_done, 0);
        run_div("12/5 after reset", 4'd12, 4'd5, 1'b0, 4'd2, 4'd2, 1'b0, 5);

        // Exhaustive, start held high; next operands applied in each done cycle.
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 256; i++) begin
            a = 4'(i >> 4);
            b = 4'(i);
            dividend = a;
            divisor  = b;
            if (b == 0) begin
                eq  = 4'd15;
                er  = a;
                edz = 1'b1;
            end else begin
                eq  = a / b;
                er  = a % b;
                edz = 1'b0;
            end
            exp_k = ((i == 0) ? 0 : 1) + ((b == 0) ? 1 : 5);
            k = 0;
            for (int c = 1; c <= 20; c++) begin
                @(negedge clk);
                if (done === 1'b1) begin
                    k = c;
                    break;
                end
            end
            check($sformatf("exh %0d/%0d interval", a, b), k, exp_k);
            check($sformatf("exh %0d/%0d quotient", a, b), quotient, eq);
            check($sformatf("exh %0d/%0d remainder", a, b), remainder, er);
            check($sformatf("exh %0d/%0d div_zero", a, b), div_zero, edz);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
